// File: rtl/sprite_dma_controller_pkg.sv
// Shared constants for the sprite DMA engine: register map,
// CTRL bit positions and controller state encoding.
package sprite_dma_controller_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_REQ  = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sprite_dma_controller_addr_counter.sv
// Loadable post-incrementing address register; wraps modulo 2**W.
module dma_addr_counter
    import sprite_dma_controller_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] addr_o
);

    logic [W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = addr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sprite_dma_controller.sv
// Vblank-gated DMA from program memory into sprite object RAM,
// configured through four CPU-visible registers.
module sprite_dma_controller
    import sprite_dma_controller_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DST_W  = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [15:0]       cfg_wdata,
    output logic [15:0]       cfg_rdata,
    input  logic              vbright,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_en,
    input  logic [15:0]       src_data,
    output logic [DST_W-1:0]  dst_addr,
    output logic              dst_we,
    output logic [15:0]       dst_data,
    output logic              busy,
    output logic              done_irq
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2**DST_W);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] src_cfg_q, src_cfg_d;
    logic [DST_W-1:0]  dst_cfg_q, dst_cfg_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_rem_q, rd_rem_d;
    logic [LEN_W-1:0]  wr_rem_q, wr_rem_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;

    logic             ctrl_wr;
    logic             abort_now;
    logic             start_now;
    logic             cfg_ok;
    logic [LEN_W-1:0] len_eff;
    logic             rd_fire;
    logic             wr_fire;
    logic             last_wr;

    assign ctrl_wr   = cfg_we && (cfg_sel == REG_CTRL);
    assign abort_now = ctrl_wr && cfg_wdata[CTRL_ABORT];
    assign start_now = ctrl_wr && cfg_wdata[CTRL_START]
                       && !cfg_wdata[CTRL_ABORT]
                       && (state_q == S_IDLE);
    assign cfg_ok    = cfg_we && (state_q == S_IDLE);
    assign len_eff   = (len_q > LEN_MAX) ? LEN_MAX : len_q;

    // A granted REQ cycle already streams its first read.
    assign rd_fire = ((state_q == S_REQ) || (state_q == S_XFER))
                     && bus_gnt && !vbright
                     && (rd_rem_q != '0) && !abort_now;
    assign wr_fire = pend_q && !abort_now;
    assign last_wr = wr_fire && (wr_rem_q == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_now) begin
                    state_d = (len_q == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (!vbright) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (vbright) begin
                    state_d = S_ARM;
                end else if (bus_gnt) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // Reads stop as soon as vbright rises, so the only
                // outstanding write drains in this same cycle.
                if (last_wr) begin
                    state_d = S_DONE;
                end else if (vbright) begin
                    state_d = S_ARM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_now) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy     = (state_q == S_ARM) || (state_q == S_REQ)
                   || (state_q == S_XFER);
        bus_req  = ((state_q == S_REQ)
                    || ((state_q == S_XFER) && !vbright))
                   && !abort_now;
        done_irq = (state_q == S_DONE);
        src_en   = rd_fire;
        dst_we   = wr_fire;
        dst_data = wr_fire ? src_data : '0;
    end

    always_comb begin
        src_cfg_d = src_cfg_q;
        dst_cfg_d = dst_cfg_q;
        len_d     = len_q;
        if (cfg_ok) begin
            unique case (cfg_sel)
                REG_SRC:  src_cfg_d = ADDR_W'(cfg_wdata);
                REG_DST:  dst_cfg_d = cfg_wdata[DST_W-1:0];
                REG_LEN:  len_d     = cfg_wdata[LEN_W-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        rd_rem_d = rd_rem_q;
        wr_rem_d = wr_rem_q;
        pend_d   = rd_fire;
        done_d   = done_q;
        if (start_now) begin
            rd_rem_d = len_eff;
            wr_rem_d = len_eff;
        end else begin
            if (rd_fire) begin
                rd_rem_d = rd_rem_q - LEN_W'(1);
            end
            if (wr_fire) begin
                wr_rem_d = wr_rem_q - LEN_W'(1);
            end
        end
        if (abort_now) begin
            rd_rem_d = '0;
            wr_rem_d = '0;
        end
        if (ctrl_wr) begin
            done_d = 1'b0;
        end
        if ((state_q == S_DONE) && !abort_now) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_cfg_q <= '0;
            dst_cfg_q <= '0;
            len_q     <= '0;
            rd_rem_q  <= '0;
            wr_rem_q  <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            src_cfg_q <= src_cfg_d;
            dst_cfg_q <= dst_cfg_d;
            len_q     <= len_d;
            rd_rem_q  <= rd_rem_d;
            wr_rem_q  <= wr_rem_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
        end
    end

    dma_addr_counter #(
        .W (ADDR_W)
    ) u_src_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (start_now),
        .load_val_i (src_cfg_q),
        .inc_i      (rd_fire),
        .addr_o     (src_addr)
    );

    dma_addr_counter #(
        .W (DST_W)
    ) u_dst_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (start_now),
        .load_val_i (dst_cfg_q),
        .inc_i      (wr_fire),
        .addr_o     (dst_addr)
    );

    always_comb begin
        unique case (cfg_sel)
            REG_SRC:  cfg_rdata = 16'(src_cfg_q);
            REG_DST:  cfg_rdata = 16'(dst_cfg_q);
            REG_LEN:  cfg_rdata = 16'(len_q);
            REG_CTRL: cfg_rdata = {busy, done_q, 14'(wr_rem_q)};
            default:  cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sprite_dma_controller.sv
// Scoreboard bench for sprite_dma_controller: directed transfers,
// checked by a negedge monitor against queued reads and writes.
module tb_sprite_dma_controller;
    import sprite_dma_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        vbright;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] src_addr;
    logic        src_en;
    logic [15:0] src_data;
    logic [9:0]  dst_addr;
    logic        dst_we;
    logic [15:0] dst_data;
    logic        busy;
    logic        done_irq;

    int n_cmp = 0;
    int n_bad = 0;
    int src_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic prev_rd = 1'b0;

    logic [15:0] exp_src[$];
    logic [25:0] exp_wr[$];

    sprite_dma_controller dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .vbright   (vbright),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .src_addr  (src_addr),
        .src_en    (src_en),
        .src_data  (src_data),
        .dst_addr  (dst_addr),
        .dst_we    (dst_we),
        .dst_data  (dst_data),
        .busy      (busy),
        .done_irq  (done_irq)
    );

    always #5 clk = ~clk;

    // Program memory: word content is its address xor 0x5A3C.
    always @(posedge clk or posedge rst) begin
        if (rst) src_data <= '0;
        else if (src_en) src_data <= src_addr ^ 16'h5A3C;
    end

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (src_en) begin
                src_cnt++;
                check("rd_gnt", {31'b0, bus_gnt}, 1);
                check("rd_req", {31'b0, bus_req}, 1);
                if (exp_src.size() == 0)
                    check("rd_extra", exp_src.size(), 1);
                else
                    check("rd_addr", {16'b0, src_addr}, {16'b0, exp_src.pop_front()});
            end
            if (dst_we) begin
                wr_cnt++;
                check("wr_after_rd", {31'b0, prev_rd}, 1);
                if (exp_wr.size() == 0)
                    check("wr_extra", exp_wr.size(), 1);
                else
                    check("wr_word", {6'b0, dst_addr, dst_data}, {6'b0, exp_wr.pop_front()});
            end
            if (done_irq) done_cnt++;
            prev_rd = src_en;
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] sel,
                            input logic [15:0] exp);
        cfg_sel = sel;
        #1;
        check(name, {16'b0, cfg_rdata}, {16'b0, exp});
    endtask

    task automatic push(input logic [15:0] s, input logic [9:0] d,
                        input int nrd, input int nwr);
        for (int i = 0; i < nrd; i++) exp_src.push_back(s + 16'(i));
        for (int i = 0; i < nwr; i++)
            exp_wr.push_back({d + 10'(i), (s + 16'(i)) ^ 16'h5A3C});
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l);
        cfg_write(REG_SRC, s);
        cfg_write(REG_DST, d);
        cfg_write(REG_LEN, l);
    endtask

    task automatic wait_done(input string name, input int max);
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < max) begin
            @(posedge clk);
            c++;
        end
        check(name, done_cnt - d0, 1);
    endtask

    task automatic wait_reads(input string name, input int n, input int max);
        int seen = 0;
        int c = 0;
        while (seen < n && c < max) begin
            @(posedge clk); #1;
            if (src_en) seen++;
            c++;
        end
        check(name, seen, n);
    endtask

    task automatic queues_empty(input string name);
        check({name, "_rd_left"}, exp_src.size(), 0);
        check({name, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, d0;
        logic seen;
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = '0;
        vbright = 1'b1; bus_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd_check("rst_src", REG_SRC, 16'h0000);
        rd_check("rst_dst", REG_DST, 16'h0000);
        rd_check("rst_len", REG_LEN, 16'h0000);
        rd_check("rst_status", REG_CTRL, 16'h0000);
        check("rst_outs", {27'b0, busy, bus_req, src_en, dst_we, done_irq}, 0);
        check("rst_addr", {6'b0, src_addr, dst_addr}, 0);

        // Basic 4-word copy, grant tied high
        setup(16'h0100, 16'h0010, 16'd4);
        rd_check("t1_src_rb", REG_SRC, 16'h0100);
        rd_check("t1_dst_rb", REG_DST, 16'h0010);
        rd_check("t1_len_rb", REG_LEN, 16'h0004);
        vbright = 1'b0; bus_gnt = 1'b1;
        s0 = src_cnt; w0 = wr_cnt;
        push(16'h0100, 10'h010, 4, 4);
        cfg_write(REG_CTRL, 16'h0001);
        wait_done("t1_done", 50);
        repeat (2) @(posedge clk); #1;
        rd_check("t1_status", REG_CTRL, 16'h4000);
        check("t1_reads", src_cnt - s0, 4);
        check("t1_writes", wr_cnt - w0, 4);
        queues_empty("t1");

        // Arm during visible lines, release 20 cycles later
        vbright = 1'b1; bus_gnt = 1'b0;
        setup(16'h2000, 16'h0100, 16'd2);
        push(16'h2000, 10'h100, 2, 2);
        cfg_write(REG_CTRL, 16'h0001);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus_req) seen = 1'b1;
        end
        check("t2_req_low", {31'b0, seen}, 0);
        check("t2_busy", {31'b0, busy}, 1);
        vbright = 1'b0;
        @(posedge clk); #1;
        check("t2_req_rise", {31'b0, bus_req}, 1);
        check("t2_no_rd_yet", {31'b0, src_en}, 0);
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        #1;
        check("t2_first_rd", {31'b0, src_en}, 1);
        wait_done("t2_done", 50);
        queues_empty("t2");

        // Vblank ends after 3 reads, resume next blanking
        setup(16'h0300, 16'h0020, 16'd8);
        push(16'h0300, 10'h020, 8, 8);
        s0 = src_cnt; w0 = wr_cnt;
        cfg_write(REG_CTRL, 16'h0001);
        wait_reads("t3_three_rd", 3, 30);
        @(posedge clk); #1;
        vbright = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("t3_mid_reads", src_cnt - s0, 3);
        check("t3_mid_writes", wr_cnt - w0, 3);
        check("t3_mid_req", {31'b0, bus_req}, 0);
        check("t3_mid_busy", {31'b0, busy}, 1);
        rd_check("t3_mid_status", REG_CTRL, 16'h8005);
        vbright = 1'b0;
        wait_done("t3_done", 50);
        check("t3_writes", wr_cnt - w0, 8);
        queues_empty("t3");

        // Destination and source wrap
        setup(16'hFFFE, 16'h03FE, 16'd4);
        exp_src.push_back(16'hFFFE); exp_src.push_back(16'hFFFF);
        exp_src.push_back(16'h0000); exp_src.push_back(16'h0001);
        exp_wr.push_back({10'h3FE, 16'hA5C2});
        exp_wr.push_back({10'h3FF, 16'hA5C3});
        exp_wr.push_back({10'h000, 16'h5A3C});
        exp_wr.push_back({10'h001, 16'h5A3D});
        cfg_write(REG_CTRL, 16'h0001);
        wait_done("t4_done", 50);
        #1;
        check("t4_dst_next", {22'b0, dst_addr}, 32'h002);
        check("t4_src_next", {16'b0, src_addr}, 32'h0002);
        queues_empty("t4");

        // Grant withdrawn for two cycles
        setup(16'h0400, 16'h0040, 16'd6);
        push(16'h0400, 10'h040, 6, 6);
        w0 = wr_cnt;
        cfg_write(REG_CTRL, 16'h0001);
        wait_reads("t5_two_rd", 2, 30);
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #1 check("t5_gnt_low_a", {31'b0, src_en}, 0);
        @(posedge clk); #1;
        check("t5_gnt_low_b", {31'b0, src_en}, 0);
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        wait_done("t5_done", 50);
        check("t5_writes", wr_cnt - w0, 6);
        queues_empty("t5");

        // Abort after 3 reads: pending write dropped, no irq
        setup(16'h0500, 16'h0080, 16'd8);
        push(16'h0500, 10'h080, 3, 2);
        s0 = src_cnt; w0 = wr_cnt;
        cfg_write(REG_CTRL, 16'h0001);
        wait_reads("t6_three_rd", 3, 30);
        d0 = done_cnt;
        cfg_write(REG_CTRL, 16'h0002);
        check("t6_idle", {31'b0, busy}, 0);
        repeat (3) @(posedge clk); #1;
        check("t6_reads", src_cnt - s0, 3);
        check("t6_writes", wr_cnt - w0, 2);
        check("t6_no_irq", done_cnt - d0, 0);
        cfg_sel = REG_CTRL; #1;
        check("t6_flags", {30'b0, cfg_rdata[15:14]}, 0);
        queues_empty("t6");

        // Zero length completes without bus activity
        cfg_write(REG_LEN, 16'd0);
        s0 = src_cnt;
        cfg_write(REG_CTRL, 16'h0001);
        wait_done("t7_done", 10);
        repeat (2) @(posedge clk); #1;
        check("t7_no_reads", src_cnt - s0, 0);
        rd_check("t7_status", REG_CTRL, 16'h4000);

        // Length clamp, writes ignored while busy, start+abort
        vbright = 1'b1;
        setup(16'h0AAA, 16'h0000, 16'h07FF);
        rd_check("t8_len_rb", REG_LEN, 16'h07FF);
        cfg_write(REG_CTRL, 16'h0001);
        rd_check("t8_clamp", REG_CTRL, 16'h8400);
        cfg_write(REG_SRC, 16'h1234);
        rd_check("t8_src_locked", REG_SRC, 16'h0AAA);
        cfg_write(REG_CTRL, 16'h0003);
        check("t8_abort_idle", {31'b0, busy}, 0);
        cfg_write(REG_CTRL, 16'h0003);
        check("t8_start_abort", {31'b0, busy}, 0);
        queues_empty("t8");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
